// File: rtl/data_memory_32_pkg.sv
// Shared definitions for the data memory and the decode stage.
//   ADDR_WORD / ADDR_HALF / ADDR_BYTE : access-size codes carried on the *_addressing buses.
//   Code 2'b10 is not listed and is treated as a word access.
package data_memory_32_pkg;

  localparam logic [1:0] ADDR_WORD = 2'b00;
  localparam logic [1:0] ADDR_HALF = 2'b01;
  localparam logic [1:0] ADDR_BYTE = 2'b11;

  // Byte lanes in one 32-bit bus word.
  localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/data_memory_32_mem_lane_decode.sv
// mem_lane_decode: combinational access decoder for one memory port.
//   addr       in   NB_ADDRESS  byte address as presented by the CPU
//   addressing in   2           access size code (word / half / byte)
//   base_addr  out  NB_ADDRESS  aligned address of lane 0 of the access
//   lane_mask  out  4           lane j active means byte base_addr+j takes part
// Misaligned addresses are silently aligned down; there is no error output.
module mem_lane_decode
  import data_memory_32_pkg::*;
#(
  parameter int unsigned NB_ADDRESS = 6
) (
  input  logic [NB_ADDRESS-1:0] addr,
  input  logic [1:0]            addressing,
  output logic [NB_ADDRESS-1:0] base_addr,
  output logic [NUM_LANES-1:0]  lane_mask
);

  always_comb begin
    base_addr = addr;
    lane_mask = 4'b1111;
    case (addressing)
      ADDR_HALF: begin
        base_addr    = addr;
        base_addr[0] = 1'b0;
        lane_mask    = 4'b0011;
      end
      ADDR_BYTE: begin
        base_addr = addr;
        lane_mask = 4'b0001;
      end
      default: begin
        // ADDR_WORD and the unused code 2'b10 both behave as word accesses.
        base_addr      = addr;
        base_addr[1:0] = 2'b00;
        lane_mask      = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_32.sv
// data_memory_32: 64-byte little-endian data memory for the MEM stage.
//   i_clk          in   1            clock, rising edge
//   i_rst_n        in   1            asynchronous active-low reset, clears memory and o_r_data
//   i_w_addr       in   NB_ADDRESS   write byte address
//   i_w_data       in   NB_DATA_BUS  write payload, always in the low bits
//   i_w_en         in   1            write enable
//   i_w_addressing in   2            write size code
//   i_r_addr       in   NB_ADDRESS   read byte address
//   i_r_en         in   1            read enable
//   i_r_addressing in   2            read size code
//   o_r_data       out  NB_DATA_BUS  registered, zero-extended read data (1-cycle latency)
// A read and a write on the same edge see the old contents (read-before-write).
module data_memory_32
  import data_memory_32_pkg::*;
#(
  parameter int unsigned NB_DATA_BUS = 32,
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_ADDRESS  = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NB_ADDRESS-1:0]  i_w_addr,
  input  logic [NB_DATA_BUS-1:0] i_w_data,
  input  logic                   i_w_en,
  input  logic [1:0]             i_w_addressing,
  input  logic [NB_ADDRESS-1:0]  i_r_addr,
  input  logic                   i_r_en,
  input  logic [1:0]             i_r_addressing,
  output logic [NB_DATA_BUS-1:0] o_r_data
);

  localparam int unsigned Depth = 2 ** NB_ADDRESS;

  logic [NB_DATA-1:0]     mem_q [Depth];
  logic [NB_DATA_BUS-1:0] r_data_q;
  logic [NB_DATA_BUS-1:0] r_data_d;

  logic [NB_ADDRESS-1:0]  w_base;
  logic [NUM_LANES-1:0]   w_mask;
  logic [NB_ADDRESS-1:0]  r_base;
  logic [NUM_LANES-1:0]   r_mask;

  mem_lane_decode #(
    .NB_ADDRESS (NB_ADDRESS)
  ) u_w_decode (
    .addr       (i_w_addr),
    .addressing (i_w_addressing),
    .base_addr  (w_base),
    .lane_mask  (w_mask)
  );

  mem_lane_decode #(
    .NB_ADDRESS (NB_ADDRESS)
  ) u_r_decode (
    .addr       (i_r_addr),
    .addressing (i_r_addressing),
    .base_addr  (r_base),
    .lane_mask  (r_mask)
  );

  // Gather the addressed bytes; inactive lanes read as zero (zero extension).
  // base+j is computed in NB_ADDRESS bits; it can only wrap on masked lanes.
  always_comb begin
    r_data_d = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (r_mask[j]) begin
        r_data_d[j*NB_DATA +: NB_DATA] = mem_q[r_base + NB_ADDRESS'(j)];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      r_data_q <= '0;
    end else begin
      if (i_w_en) begin
        for (int j = 0; j < NUM_LANES; j++) begin
          if (w_mask[j]) begin
            mem_q[w_base + NB_ADDRESS'(j)] <= i_w_data[j*NB_DATA +: NB_DATA];
          end
        end
      end
      // r_data_d was formed from pre-edge contents, giving read-before-write.
      if (i_r_en) begin
        r_data_q <= r_data_d;
      end
    end
  end

  assign o_r_data = r_data_q;

endmodule

// File: tb/tb_data_memory_32.sv
module tb_data_memory_32;

  logic        clk;
  logic        rst_n;
  logic [5:0]  w_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic [1:0]  w_addressing;
  logic [5:0]  r_addr;
  logic        r_en;
  logic [1:0]  r_addressing;
  logic [31:0] r_data;

  int tests_run;
  int tests_failed;

  data_memory_32 #(
    .NB_DATA_BUS (32),
    .NB_DATA     (8),
    .NB_ADDRESS  (6)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_w_addr       (w_addr),
    .i_w_data       (w_data),
    .i_w_en         (w_en),
    .i_w_addressing (w_addressing),
    .i_r_addr       (r_addr),
    .i_r_en         (r_en),
    .i_r_addressing (r_addressing),
    .o_r_data       (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write on the next rising edge; inputs change 1 time unit after the edge.
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    w_addr       = a;
    w_data       = d;
    w_addressing = sz;
    w_en         = 1'b1;
    @(posedge clk);
    #1;
    w_en = 1'b0;
  endtask

  // One read on the next rising edge; returns o_r_data sampled 1 unit later.
  task automatic do_read(input logic [5:0] a, input logic [1:0] sz, output logic [31:0] d);
    r_addr       = a;
    r_addressing = sz;
    r_en         = 1'b1;
    @(posedge clk);
    #1;
    r_en = 1'b0;
    d    = r_data;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    tests_run++;
    if (r_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_out: got %h expected %h", r_data, 32'h0);
    end
    do_read(6'd0, 2'b00, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mem0: got %h expected %h", d, 32'h0);
    end
    do_read(6'd60, 2'b00, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mem60: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_word;
    logic [31:0] d;
    do_write(6'd0, 32'h0123abcd, 2'b00);
    do_read(6'd0, 2'b00, d);
    tests_run++;
    if (d !== 32'h0123abcd) begin
      tests_failed++;
      $display("FAIL word_rd0: got %h expected %h", d, 32'h0123abcd);
    end
    // Top word of memory, addressed misaligned on both ports.
    do_write(6'd61, 32'hdeadbeef, 2'b00);
    do_read(6'd62, 2'b00, d);
    tests_run++;
    if (d !== 32'hdeadbeef) begin
      tests_failed++;
      $display("FAIL word_rd60: got %h expected %h", d, 32'hdeadbeef);
    end
    // Code 2'b10 behaves as a word access.
    do_write(6'd17, 32'h11223344, 2'b10);
    do_read(6'd16, 2'b10, d);
    tests_run++;
    if (d !== 32'h11223344) begin
      tests_failed++;
      $display("FAIL word_code10: got %h expected %h", d, 32'h11223344);
    end
  endtask

  task automatic test_size_reads;
    logic [31:0] d;
    do_read(6'd0, 2'b01, d);
    tests_run++;
    if (d !== 32'h0000abcd) begin
      tests_failed++;
      $display("FAIL half_rd0: got %h expected %h", d, 32'h0000abcd);
    end
    do_read(6'd0, 2'b11, d);
    tests_run++;
    if (d !== 32'h000000cd) begin
      tests_failed++;
      $display("FAIL byte_rd0: got %h expected %h", d, 32'h000000cd);
    end
    do_read(6'd3, 2'b11, d);
    tests_run++;
    if (d !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL byte_rd3: got %h expected %h", d, 32'h00000001);
    end
    do_read(6'd3, 2'b01, d);
    tests_run++;
    if (d !== 32'h00000123) begin
      tests_failed++;
      $display("FAIL half_rd3_aligned: got %h expected %h", d, 32'h00000123);
    end
  endtask

  task automatic test_half_write;
    logic [31:0] d;
    do_write(6'd4, 32'h0123abcd, 2'b01);
    do_read(6'd4, 2'b00, d);
    tests_run++;
    if (d !== 32'h0000abcd) begin
      tests_failed++;
      $display("FAIL half_wr_word4: got %h expected %h", d, 32'h0000abcd);
    end
    do_read(6'd4, 2'b01, d);
    tests_run++;
    if (d !== 32'h0000abcd) begin
      tests_failed++;
      $display("FAIL half_wr_half4: got %h expected %h", d, 32'h0000abcd);
    end
    do_read(6'd4, 2'b11, d);
    tests_run++;
    if (d !== 32'h000000cd) begin
      tests_failed++;
      $display("FAIL half_wr_byte4: got %h expected %h", d, 32'h000000cd);
    end
  endtask

  task automatic test_byte_write;
    logic [31:0] d;
    do_write(6'd9, 32'h0123abcd, 2'b11);
    do_read(6'd8, 2'b00, d);
    tests_run++;
    if (d !== 32'h0000cd00) begin
      tests_failed++;
      $display("FAIL byte_wr_word8: got %h expected %h", d, 32'h0000cd00);
    end
    do_read(6'd8, 2'b01, d);
    tests_run++;
    if (d !== 32'h0000cd00) begin
      tests_failed++;
      $display("FAIL byte_wr_half8: got %h expected %h", d, 32'h0000cd00);
    end
    do_read(6'd9, 2'b11, d);
    tests_run++;
    if (d !== 32'h000000cd) begin
      tests_failed++;
      $display("FAIL byte_wr_byte9: got %h expected %h", d, 32'h000000cd);
    end
    // Last byte of memory; other lanes of that word must survive.
    do_write(6'd63, 32'hffffff5a, 2'b11);
    do_read(6'd60, 2'b00, d);
    tests_run++;
    if (d !== 32'h5aadbeef) begin
      tests_failed++;
      $display("FAIL byte_wr_63: got %h expected %h", d, 32'h5aadbeef);
    end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    r_addr       = 6'd0;
    r_addressing = 2'b00;
    r_en         = 1'b1;
    w_addr       = 6'd0;
    w_data       = 32'hffffffff;
    w_addressing = 2'b00;
    w_en         = 1'b1;
    @(posedge clk);
    #1;
    r_en = 1'b0;
    w_en = 1'b0;
    tests_run++;
    if (r_data !== 32'h0123abcd) begin
      tests_failed++;
      $display("FAIL collide_old: got %h expected %h", r_data, 32'h0123abcd);
    end
    do_read(6'd0, 2'b00, d);
    tests_run++;
    if (d !== 32'hffffffff) begin
      tests_failed++;
      $display("FAIL collide_new: got %h expected %h", d, 32'hffffffff);
    end
    // Read port disabled, address moved, write port idle with live data: nothing changes.
    r_addr = 6'd4;
    w_addr = 6'd0;
    w_data = 32'h00000000;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (r_data !== 32'hffffffff) begin
      tests_failed++;
      $display("FAIL hold_ren0: got %h expected %h", r_data, 32'hffffffff);
    end
    do_read(6'd0, 2'b00, d);
    tests_run++;
    if (d !== 32'hffffffff) begin
      tests_failed++;
      $display("FAIL wen0_nochange: got %h expected %h", d, 32'hffffffff);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (r_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_out: got %h expected %h", r_data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(6'd0, 2'b00, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_mem0: got %h expected %h", d, 32'h0);
    end
    do_read(6'd60, 2'b00, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_mem60: got %h expected %h", d, 32'h0);
    end
    do_read(6'd8, 2'b00, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_mem8: got %h expected %h", d, 32'h0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    w_addr       = '0;
    w_data       = '0;
    w_en         = 1'b0;
    w_addressing = 2'b00;
    r_addr       = '0;
    r_en         = 1'b0;
    r_addressing = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    test_reset();
    test_word();
    test_size_reads();
    test_half_write();
    test_byte_write();
    test_collision();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
